led_pio_blink: RTL and testbench

Parametrised Avalon-MM slave output port driving a bank of LEDs or other static outputs. It is the next generation of the Qsys LED PIO and sits on the same HPS/Nios data master. New features over the fixed 10-bit PIO:
- configurable width;
- atomic SET/CLEAR registers;
- per-bit blink mode driven by an internal programmable half-period counter;
- registered `out_port`.

---
 rtl/led_pio_blink.sv | 109 ++++++++++
 tb/tb_led_pio_blink.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pio_blink.sv
// Avalon-MM LED/output PIO with atomic SET/CLEAR, per-bit blink and a registered output.
// The blink engine is a free-running half-period counter that toggles a shared phase bit.
module led_pio_blink #(
   parameter int unsigned         WIDTH        = 10,
   parameter int unsigned         PERIOD_W     = 24,
   parameter logic [WIDTH-1:0]    RESET_DATA   = '0,
   parameter logic [PERIOD_W-1:0] RESET_PERIOD = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_SET      = 3'd1;
   localparam logic [2:0] ADDR_CLEAR    = 3'd2;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd3;
   localparam logic [2:0] ADDR_PERIOD   = 3'd4;
   localparam logic [2:0] ADDR_STATUS   = 3'd5;

   logic [WIDTH-1:0]    data_q, data_d;
   logic [WIDTH-1:0]    blink_en_q, blink_en_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;
   logic [WIDTH-1:0]    out_q, out_d;

   logic                wr_en;
   logic                period_wr;
   logic [WIDTH-1:0]    wr_bits;
   logic [PERIOD_W-1:0] wr_period;
   logic                unused_writedata;

   assign wr_en            = chipselect & ~write_n;
   assign period_wr        = wr_en && (address == ADDR_PERIOD);
   assign wr_bits          = writedata[WIDTH-1:0];
   assign wr_period        = writedata[PERIOD_W-1:0];
   assign unused_writedata = ^writedata;

   always_comb begin
      data_d     = data_q;
      blink_en_d = blink_en_q;
      period_d   = period_q;
      if (wr_en) begin
         case (address)
            ADDR_DATA:     data_d     = wr_bits;
            ADDR_SET:      data_d     = data_q | wr_bits;
            ADDR_CLEAR:    data_d     = data_q & ~wr_bits;
            ADDR_BLINK_EN: blink_en_d = wr_bits;
            ADDR_PERIOD:   period_d   = wr_period;
            default:       ;
         endcase
      end
   end

   // A PERIOD write restarts the half-period cleanly, even on a wrap edge.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (period_wr || (period_q == '0)) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == period_q) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + PERIOD_W'(1);
      end
   end

   assign out_d = data_q & (~blink_en_q | {WIDTH{phase_q}});

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q     <= RESET_DATA;
         blink_en_q <= '0;
         period_q   <= RESET_PERIOD;
         cnt_q      <= '0;
         phase_q    <= 1'b1;
         out_q      <= '0;
      end else begin
         data_q     <= data_d;
         blink_en_q <= blink_en_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         out_q      <= out_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata[WIDTH-1:0] = data_q;
         ADDR_BLINK_EN:                   readdata[WIDTH-1:0] = blink_en_q;
         ADDR_PERIOD:                     readdata[PERIOD_W-1:0] = period_q;
         ADDR_STATUS:                     readdata[0] = phase_q;
         default:                         readdata = '0;
      endcase
   end

   assign out_port = out_q;

endmodule

// File: tb/tb_led_pio_blink.sv
// Bench for led_pio_blink: register access, SET/CLEAR, blink timing, PERIOD rewrite and reset.
// Expected values are queued when stimulus is applied and popped when the DUT is sampled.
module tb_led_pio_blink;

   logic        clk;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  out_port;

   led_pio_blink #(
      .WIDTH       (10),
      .PERIOD_W    (24),
      .RESET_DATA  (10'h2A5),
      .RESET_PERIOD(24'd7)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .out_port  (out_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk(e.tag, obs, e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic exp_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] d;
      sb_push(tag, exp);
      rd(a, d);
      sb_pop(d);
   endtask

   task automatic exp_out(input string tag, input logic [31:0] exp);
      sb_push(tag, exp);
      sb_pop(32'(out_port));
   endtask

   function automatic logic blink_ph(input int j);
      return ((j / 4) % 2) == 0;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;

      // reset held for 3 edges, output forced low
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_out("rst_out", 32'h0);
      end
      reset = 1'b0;
      tick();
      exp_out("rst_rel_out", 32'h2A5);
      exp_rd("rst_data", 3'd0, 32'h0000_02A5);
      exp_rd("rst_period", 3'd4, 32'd7);
      exp_rd("rst_blink_en", 3'd3, 32'h0);

      // SET/CLEAR back to back
      wr(3'd0, 32'h00F);
      wr(3'd1, 32'h300);
      wr(3'd2, 32'h005);
      exp_rd("sc_data", 3'd0, 32'h30A);
      exp_out("sc_out_lag", 32'h30F);
      tick();
      exp_out("sc_out", 32'h30A);
      wr(3'd1, 32'hFFFF_FFFF);
      exp_rd("set_all", 3'd1, 32'h3FF);
      exp_rd("clr_rd", 3'd2, 32'h3FF);

      // blink bit 0 with half-period 4
      wr(3'd0, 32'h3FF);
      wr(3'd3, 32'h001);
      wr(3'd4, 32'd3);
      for (int j = 1; j <= 11; j++) begin
         sb_push("blink_out", {22'h0, 9'h1FF, blink_ph(j - 1)});
         sb_push("blink_status", {31'h0, blink_ph(j)});
      end
      for (int j = 1; j <= 11; j++) begin
         tick();
         sb_pop(32'(out_port));
         rd(3'd5, d);
         sb_pop(d);
      end

      // PERIOD rewrite on the 1->0 wrap edge: no toggle, then half-period 2
      wr(3'd4, 32'd1);
      exp_rd("wrap_phase", 3'd5, 32'h1);
      exp_out("wrap_out", 32'h3FF);
      tick();
      exp_rd("p1_ph_n1", 3'd5, 32'h1);
      tick();
      exp_rd("p1_ph_n2", 3'd5, 32'h0);
      tick();
      exp_rd("p1_ph_n3", 3'd5, 32'h0);
      exp_out("p1_out_n3", 32'h3FE);
      tick();
      exp_rd("p1_ph_n4", 3'd5, 32'h1);

      // PERIOD = 0 stops blinking with phase held high
      tick();
      tick();
      exp_rd("p1_ph_low", 3'd5, 32'h0);
      wr(3'd4, 32'd0);
      tick();
      tick();
      tick();
      exp_rd("p0_phase", 3'd5, 32'h1);
      exp_out("p0_out", 32'h3FF);
      exp_rd("p0_period", 3'd4, 32'h0);

      // reserved address
      wr(3'd6, 32'h155);
      exp_rd("rsv_data", 3'd0, 32'h3FF);
      exp_rd("rsv_blink_en", 3'd3, 32'h001);
      exp_rd("rsv_period", 3'd4, 32'h0);
      exp_rd("rsv_rd6", 3'd6, 32'h0);
      exp_rd("rsv_rd7", 3'd7, 32'h0);

      // reset during the low phase together with a DATA write
      wr(3'd4, 32'd3);
      for (int i = 0; i < 4; i++) tick();
      exp_rd("mid_phase_low", 3'd5, 32'h0);
      tick();
      exp_out("mid_out_low", 32'h3FE);
      reset      = 1'b1;
      address    = 3'd0;
      writedata  = 32'h0F0;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      reset      = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      exp_out("mid_rst_out", 32'h0);
      exp_rd("mid_rst_data", 3'd0, 32'h2A5);
      exp_rd("mid_rst_period", 3'd4, 32'd7);
      exp_rd("mid_rst_blink_en", 3'd3, 32'h0);
      exp_rd("mid_rst_phase", 3'd5, 32'h1);
      tick();
      exp_out("mid_rel_out", 32'h2A5);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
